up_control_unit: RTL and testbench

UP_CONTROL_UNIT -- requirements
Module: up_control_unit

---
 rtl/up_control_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_up_control_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/up_control_unit.sv
// Control unit for a small 4-bit accumulator microprocessor.
// Fetches one- or two-byte instructions from ROM, sequences the datapath
// strobes during EXEC, keeps the ALU flags and resolves conditional jumps.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   FETCH   | latch opcode/operand from program_byte, advance PC
//   FETCH2  | latch second byte as low RAM/jump address, advance PC
//   EXEC    | drive datapath strobes, update flags, take jumps
module up_control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  program_byte,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic [11:0] PC,
  output logic        phase,
  output logic [3:0]  instr,
  output logic [3:0]  oprnd,
  output logic [11:0] address_RAM,
  output logic        c_flag,
  output logic        z_flag,
  output logic [2:0]  alu_sel,
  output logic        acc_we,
  output logic        ram_we,
  output logic        ram_oe,
  output logic        oprnd_oe,
  output logic        in_oe,
  output logic        out_we
);

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_NANDI = 4'hA;
  localparam logic [3:0] OP_NANDM = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_ADDI  = 4'hE;
  localparam logic [3:0] OP_ADDM  = 4'hF;

  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_CMP  = 3'b001;
  localparam logic [2:0] SEL_LDB  = 3'b010;
  localparam logic [2:0] SEL_ADD  = 3'b011;
  localparam logic [2:0] SEL_NAND = 3'b100;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_FETCH2 = 2'b01,
    ST_EXEC   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [3:0]  instr_q, instr_d;
  logic [3:0]  oprnd_q, oprnd_d;
  logic [7:0]  low_q, low_d;
  logic        c_q, c_d;
  logic        z_q, z_d;

  // Instructions carrying a low-address byte after the opcode byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    case (op)
      OP_JC, OP_JNC, OP_CMPM, OP_LD, OP_ST,
      OP_JZ, OP_JNZ, OP_NANDM, OP_JMP, OP_ADDM: is_two_byte = 1'b1;
      default:                                  is_two_byte = 1'b0;
    endcase
  endfunction

  // Compare, NAND and ADD variants are the only ALU results that set flags.
  function automatic logic updates_flags(input logic [3:0] op);
    case (op)
      OP_CMPI, OP_CMPM, OP_NANDI, OP_NANDM, OP_ADDI, OP_ADDM: updates_flags = 1'b1;
      default:                                               updates_flags = 1'b0;
    endcase
  endfunction

  // Jump decision uses registered flags only, never this cycle's ALU result.
  function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
    case (op)
      OP_JC:   jump_taken = c;
      OP_JNC:  jump_taken = ~c;
      OP_JZ:   jump_taken = z;
      OP_JNZ:  jump_taken = ~z;
      OP_JMP:  jump_taken = 1'b1;
      default: jump_taken = 1'b0;
    endcase
  endfunction

  // State and datapath registers; reset acts immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= 12'h000;
      instr_q <= 4'h0;
      oprnd_q <= 4'h0;
      low_q   <= 8'h00;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      oprnd_q <= oprnd_d;
      low_q   <= low_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Next-state sequencing through the fetch/execute cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = is_two_byte(program_byte[7:4]) ? ST_FETCH2 : ST_EXEC;
      ST_FETCH2: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Next values for PC, instruction latches, low address byte and flags.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    oprnd_d = oprnd_q;
    low_d   = low_q;
    c_d     = c_q;
    z_d     = z_q;
    case (state_q)
      ST_FETCH: begin
        instr_d = program_byte[7:4];
        oprnd_d = program_byte[3:0];
        pc_d    = pc_q + 12'd1;
      end
      ST_FETCH2: begin
        low_d = program_byte;
        pc_d  = pc_q + 12'd1;
      end
      ST_EXEC: begin
        if (jump_taken(instr_q, c_q, z_q)) begin
          pc_d = {oprnd_q, low_q};
        end
        if (updates_flags(instr_q)) begin
          c_d = alu_c;
          z_d = alu_z;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Datapath strobes: decoded from state and opcode, idle outside EXEC.
  always_comb begin
    alu_sel  = SEL_PASS;
    acc_we   = 1'b0;
    ram_we   = 1'b0;
    ram_oe   = 1'b0;
    oprnd_oe = 1'b0;
    in_oe    = 1'b0;
    out_we   = 1'b0;
    if (state_q == ST_EXEC) begin
      case (instr_q)
        OP_CMPI: begin
          oprnd_oe = 1'b1;
          alu_sel  = SEL_CMP;
        end
        OP_CMPM: begin
          ram_oe  = 1'b1;
          alu_sel = SEL_CMP;
        end
        OP_LIT: begin
          oprnd_oe = 1'b1;
          alu_sel  = SEL_LDB;
          acc_we   = 1'b1;
        end
        OP_IN: begin
          in_oe   = 1'b1;
          alu_sel = SEL_LDB;
          acc_we  = 1'b1;
        end
        OP_LD: begin
          ram_oe  = 1'b1;
          alu_sel = SEL_LDB;
          acc_we  = 1'b1;
        end
        OP_ST: begin
          ram_we = 1'b1;
        end
        OP_NANDI: begin
          oprnd_oe = 1'b1;
          alu_sel  = SEL_NAND;
          acc_we   = 1'b1;
        end
        OP_NANDM: begin
          ram_oe  = 1'b1;
          alu_sel = SEL_NAND;
          acc_we  = 1'b1;
        end
        OP_OUT: begin
          out_we = 1'b1;
        end
        OP_ADDI: begin
          oprnd_oe = 1'b1;
          alu_sel  = SEL_ADD;
          acc_we   = 1'b1;
        end
        OP_ADDM: begin
          ram_oe  = 1'b1;
          alu_sel = SEL_ADD;
          acc_we  = 1'b1;
        end
        default: begin
          alu_sel = SEL_PASS;
        end
      endcase
    end
  end

  assign PC          = pc_q;
  assign phase       = (state_q == ST_EXEC);
  assign instr       = instr_q;
  assign oprnd       = oprnd_q;
  assign address_RAM = {oprnd_q, low_q};
  assign c_flag      = c_q;
  assign z_flag      = z_q;

endmodule

// File: tb/tb_up_control_unit.sv
`timescale 1ns/1ps
// Bench for up_control_unit: per-opcode vector table, directed multi-cycle
// sequences and a random program run against an instruction-level model.
module tb_up_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  program_byte;
  logic        alu_c, alu_z;
  logic [11:0] PC;
  logic        phase;
  logic [3:0]  instr, oprnd;
  logic [11:0] address_RAM;
  logic        c_flag, z_flag;
  logic [2:0]  alu_sel;
  logic        acc_we, ram_we, ram_oe, oprnd_oe, in_oe, out_we;
  logic [8:0]  strb;

  up_control_unit dut (
    .clock(clock), .reset(reset), .program_byte(program_byte),
    .alu_c(alu_c), .alu_z(alu_z), .PC(PC), .phase(phase),
    .instr(instr), .oprnd(oprnd), .address_RAM(address_RAM),
    .c_flag(c_flag), .z_flag(z_flag), .alu_sel(alu_sel),
    .acc_we(acc_we), .ram_we(ram_we), .ram_oe(ram_oe),
    .oprnd_oe(oprnd_oe), .in_oe(in_oe), .out_we(out_we)
  );

  always #5 clock = ~clock;

  assign strb = {alu_sel, acc_we, ram_we, ram_oe, oprnd_oe, in_oe, out_we};

  // {alu_sel, acc_we, ram_we, ram_oe, oprnd_oe, in_oe, out_we} in EXEC,
  // length, flag update, and PC after EXEC for operand 5 / second byte 0x3C
  // with flags clear and alu_c=alu_z=1.
  typedef struct {
    logic [3:0]  op;
    logic [8:0]  strb;
    logic        two;
    logic        flags;
    logic [11:0] pc_after;
  } vec_t;

  vec_t        tbl[16];
  logic [7:0]  rom[4096];
  int          checks, errors;

  logic [11:0] m_pc;
  logic [7:0]  m_low;
  logic        m_c, m_z;

  function automatic vec_t mk(input logic [3:0] op, input logic [8:0] s,
                              input logic two, input logic flg, input logic [11:0] pa);
    vec_t v;
    v.op = op; v.strb = s; v.two = two; v.flags = flg; v.pc_after = pa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_pc = 12'h000; m_low = 8'h00; m_c = 1'b0; m_z = 1'b0;
  endtask

  // Execute one instruction from rom against the model; called just after a negedge.
  task automatic run_instr(input bit rnd, input logic c_in, input logic z_in);
    logic [7:0] b0;
    vec_t       r;
    logic       taken;
    b0 = rom[m_pc];
    r  = tbl[b0[7:4]];
    program_byte = b0;
    #1;
    chk("fetch_phase", 32'(phase), 32'(0));
    chk("fetch_pc", 32'(PC), 32'(m_pc));
    chk("fetch_strb", 32'(strb), 32'(0));
    @(negedge clock);
    m_pc = m_pc + 12'd1;
    if (r.two) begin
      program_byte = rom[m_pc];
      #1;
      chk("fetch2_phase", 32'(phase), 32'(0));
      chk("fetch2_pc", 32'(PC), 32'(m_pc));
      chk("fetch2_strb", 32'(strb), 32'(0));
      @(negedge clock);
      m_low = rom[m_pc];
      m_pc  = m_pc + 12'd1;
    end
    program_byte = 8'($urandom);
    alu_c = rnd ? 1'($urandom_range(0, 1)) : c_in;
    alu_z = rnd ? 1'($urandom_range(0, 1)) : z_in;
    #1;
    chk("exec_phase", 32'(phase), 32'(1));
    chk("exec_instr", 32'(instr), 32'(b0[7:4]));
    chk("exec_oprnd", 32'(oprnd), 32'(b0[3:0]));
    chk("exec_addr", 32'(address_RAM), 32'({b0[3:0], m_low}));
    chk("exec_strb", 32'(strb), 32'(r.strb));
    chk("exec_pc", 32'(PC), 32'(m_pc));
    chk("exec_flags", 32'({c_flag, z_flag}), 32'({m_c, m_z}));
    chk("exec_src_excl", 32'(((32'(ram_oe) + 32'(oprnd_oe) + 32'(in_oe)) <= 1)), 32'(1));
    chk("exec_ram_rw", 32'(ram_we & ram_oe), 32'(0));
    @(negedge clock);
    case (b0[7:4])
      4'h0:    taken = m_c;
      4'h1:    taken = ~m_c;
      4'h8:    taken = m_z;
      4'h9:    taken = ~m_z;
      4'hC:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (taken) m_pc = {b0[3:0], m_low};
    if (r.flags) begin
      m_c = alu_c;
      m_z = alu_z;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; program_byte = 8'h00; alu_c = 1'b0; alu_z = 1'b0;
    tbl[0]  = mk(4'h0, 9'b000_000000, 1'b1, 1'b0, 12'h002);
    tbl[1]  = mk(4'h1, 9'b000_000000, 1'b1, 1'b0, 12'h53C);
    tbl[2]  = mk(4'h2, 9'b001_000100, 1'b0, 1'b1, 12'h001);
    tbl[3]  = mk(4'h3, 9'b001_001000, 1'b1, 1'b1, 12'h002);
    tbl[4]  = mk(4'h4, 9'b010_100100, 1'b0, 1'b0, 12'h001);
    tbl[5]  = mk(4'h5, 9'b010_100010, 1'b0, 1'b0, 12'h001);
    tbl[6]  = mk(4'h6, 9'b010_101000, 1'b1, 1'b0, 12'h002);
    tbl[7]  = mk(4'h7, 9'b000_010000, 1'b1, 1'b0, 12'h002);
    tbl[8]  = mk(4'h8, 9'b000_000000, 1'b1, 1'b0, 12'h002);
    tbl[9]  = mk(4'h9, 9'b000_000000, 1'b1, 1'b0, 12'h53C);
    tbl[10] = mk(4'hA, 9'b100_100100, 1'b0, 1'b1, 12'h001);
    tbl[11] = mk(4'hB, 9'b100_101000, 1'b1, 1'b1, 12'h002);
    tbl[12] = mk(4'hC, 9'b000_000000, 1'b1, 1'b0, 12'h53C);
    tbl[13] = mk(4'hD, 9'b000_000001, 1'b0, 1'b0, 12'h001);
    tbl[14] = mk(4'hE, 9'b011_100100, 1'b0, 1'b1, 12'h001);
    tbl[15] = mk(4'hF, 9'b011_101000, 1'b1, 1'b1, 12'h002);

    // Reset values while reset is held low.
    #2;
    chk("rst_pc", 32'(PC), 32'(0));
    chk("rst_phase", 32'(phase), 32'(0));
    chk("rst_strb", 32'(strb), 32'(0));
    chk("rst_instr_oprnd", 32'({instr, oprnd}), 32'(0));
    chk("rst_addr", 32'(address_RAM), 32'(0));
    chk("rst_flags", 32'({c_flag, z_flag}), 32'(0));

    // Per-opcode vector table.
    for (int i = 0; i < 16; i++) begin
      vec_t r;
      r = tbl[i];
      alu_c = 1'b0; alu_z = 1'b0;
      do_reset();
      program_byte = {r.op, 4'h5};
      #1;
      chk("tbl_fetch_pc", 32'(PC), 32'(0));
      @(negedge clock);
      if (r.two) begin
        chk("tbl_fetch2_phase", 32'(phase), 32'(0));
        chk("tbl_fetch2_pc", 32'(PC), 32'(1));
        program_byte = 8'h3C;
        @(negedge clock);
      end
      alu_c = 1'b1; alu_z = 1'b1; program_byte = 8'h00;
      #1;
      chk($sformatf("tbl_exec_phase_op%0h", r.op), 32'(phase), 32'(1));
      chk($sformatf("tbl_exec_instr_op%0h", r.op), 32'({instr, oprnd}), 32'({r.op, 4'h5}));
      chk($sformatf("tbl_exec_strb_op%0h", r.op), 32'(strb), 32'(r.strb));
      chk($sformatf("tbl_exec_addr_op%0h", r.op), 32'(address_RAM),
          32'(r.two ? 12'h53C : 12'h500));
      @(negedge clock);
      chk($sformatf("tbl_after_phase_op%0h", r.op), 32'(phase), 32'(0));
      chk($sformatf("tbl_after_pc_op%0h", r.op), 32'(PC), 32'(r.pc_after));
      chk($sformatf("tbl_after_flags_op%0h", r.op), 32'({c_flag, z_flag}),
          32'(r.flags ? 2'b11 : 2'b00));
    end

    // LIT then reset pulse in the middle of EXEC.
    alu_c = 1'b0; alu_z = 1'b0;
    do_reset();
    program_byte = 8'h47;
    @(negedge clock);
    chk("lit_pc", 32'(PC), 32'(1));
    chk("lit_exec", 32'({phase, acc_we, oprnd_oe, alu_sel}), 32'({3'b111, 3'b010}));
    reset = 1'b0;
    #1;
    chk("midrst_pc", 32'(PC), 32'(0));
    chk("midrst_phase", 32'(phase), 32'(0));
    chk("midrst_strb", 32'(strb), 32'(0));
    reset = 1'b1;
    #1;
    chk("midrst_hold_pc", 32'(PC), 32'(0));
    @(negedge clock);
    chk("post_rst_fetch", 32'({PC, instr, oprnd}), 32'({12'h001, 8'h47}));
    @(negedge clock);
    chk("lit_done_phase", 32'(phase), 32'(0));

    // JMP 0x123.
    do_reset();
    rom[0] = 8'hC1; rom[1] = 8'h23;
    run_instr(1'b0, 1'b0, 1'b0);
    chk("jmp_pc", 32'(PC), 32'(12'h123));
    chk("jmp_addr", 32'(address_RAM), 32'(12'h123));

    // ADDI with carry, then JC taken; repeat with no carry.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      rom[0] = 8'hE0; rom[1] = 8'h00; rom[2] = 8'h50;
      run_instr(1'b0, (k == 0), 1'b0);
      chk("addi_cflag", 32'(c_flag), 32'(k == 0));
      run_instr(1'b0, 1'b0, 1'b0);
      chk("jc_pc", 32'(PC), 32'(k == 0 ? 12'h050 : 12'h003));
    end

    // Flags set, then ST must leave them alone.
    do_reset();
    rom[0] = 8'hE0; rom[1] = 8'h7A; rom[2] = 8'hBC;
    run_instr(1'b0, 1'b1, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0);
    chk("st_addr", 32'(address_RAM), 32'(12'hABC));
    chk("st_flags", 32'({c_flag, z_flag}), 32'(2'b11));

    // PC wrap: jump to 0xFFF and fetch a single-byte LIT there.
    do_reset();
    rom[0] = 8'hCF; rom[1] = 8'hFF; rom[12'hFFF] = 8'h41;
    run_instr(1'b0, 1'b0, 1'b0);
    chk("wrap_pre_pc", 32'(PC), 32'(12'hFFF));
    program_byte = rom[12'hFFF];
    @(negedge clock);
    chk("wrap_pc", 32'(PC), 32'(12'h000));
    chk("wrap_phase", 32'(phase), 32'(1));
    @(negedge clock);

    // Random program against the instruction-level model.
    for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 400; n++) run_instr(1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
